// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller with a load-use scoreboard and a stale-fetch drop FSM.
// Per-cause stall counters exist only when HAZARD_PERF_CNT_EN is defined, otherwise they read 0.
module hazard_stall_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int REG_ADDR_W  = 5,
  parameter int LU_DIST     = 2,
  parameter int REDIR_STAGE = 2,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_mem_resp,
  input  logic                  data_mem_req,
  input  logic                  data_mem_resp,
  input  logic                  redirect,
  input  logic [REG_ADDR_W-1:0] dec_rs1_id,
  input  logic [REG_ADDR_W-1:0] dec_rs2_id,
  input  logic                  dec_uses_rs1,
  input  logic                  dec_uses_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd_id,
  output logic                  load_pc,
  output logic [NUM_STAGES-2:0] stage_load,
  output logic [NUM_STAGES-2:0] stage_flush,
  output logic                  ir_nop_sel,
  output logic [CNT_W-1:0]      stall_dmiss_cnt,
  output logic [CNT_W-1:0]      stall_lu_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam int NR = NUM_STAGES - 1;

  typedef enum logic {RUN = 1'b0, DROP = 1'b1} state_e;

  state_e                             state_q, state_d;
  logic [LU_DIST-1:0]                 sb_vld_q, sb_vld_d;
  logic [LU_DIST-1:0][REG_ADDR_W-1:0] sb_rd_q, sb_rd_d;
  logic                               dmiss, advance, lu_hazard;

  function automatic logic rd_hit(input logic [REG_ADDR_W-1:0] rd,
                                  input logic [REG_ADDR_W-1:0] rs1,
                                  input logic [REG_ADDR_W-1:0] rs2,
                                  input logic u1, input logic u2);
    return (rd != '0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
  endfunction

  assign dmiss   = data_mem_req & ~data_mem_resp;
  assign advance = ~dmiss;

  always_comb begin
    lu_hazard = ex_is_load & rd_hit(ex_rd_id, dec_rs1_id, dec_rs2_id, dec_uses_rs1, dec_uses_rs2);
    for (int i = 0; i < LU_DIST; i++)
      if (sb_vld_q[i] && rd_hit(sb_rd_q[i], dec_rs1_id, dec_rs2_id, dec_uses_rs1, dec_uses_rs2))
        lu_hazard = 1'b1;
  end

  always_comb begin
    load_pc     = 1'b1;
    stage_load  = '1;
    stage_flush = '0;
    ir_nop_sel  = 1'b0;
    state_d     = state_q;
    sb_vld_d    = sb_vld_q;
    sb_rd_d     = sb_rd_q;
    if (dmiss) begin
      load_pc    = 1'b0;
      stage_load = '0;
    end else begin
      sb_vld_d[0] = ex_is_load & (ex_rd_id != '0);
      sb_rd_d[0]  = ex_rd_id;
      // entry i-1 currently sits past register i+1; drop it only if that register is flushed
      for (int i = 1; i < LU_DIST; i++) begin
        sb_vld_d[i] = sb_vld_q[i-1] & ~(redirect && (i + 1 < REDIR_STAGE));
        sb_rd_d[i]  = sb_rd_q[i-1];
      end
      if (redirect) begin
        // PC always takes the target; a fetch still in flight is stale either way
        for (int i = 0; i < NR; i++)
          if (i < REDIR_STAGE) stage_flush[i] = 1'b1;
        ir_nop_sel = (state_q == DROP);
        if (state_q == RUN && !instr_mem_resp) state_d = DROP;
      end else if (lu_hazard) begin
        load_pc        = 1'b0;
        stage_load[0]  = 1'b0;
        stage_flush[1] = 1'b1;
        if (state_q == DROP) begin
          ir_nop_sel = 1'b1;
          if (instr_mem_resp) state_d = RUN;
        end
      end else if (state_q == DROP) begin
        load_pc    = 1'b0;
        ir_nop_sel = 1'b1;
        if (instr_mem_resp) begin
          stage_flush[0] = 1'b1;
          state_d        = RUN;
        end
      end else if (!instr_mem_resp) begin
        load_pc    = 1'b0;
        ir_nop_sel = 1'b1;
      end
    end
    if (!rst) begin
      load_pc     = 1'b1;
      stage_load  = '1;
      stage_flush = '0;
      ir_nop_sel  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      sb_vld_q <= '0;
      sb_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      sb_vld_q <= sb_vld_d;
      sb_rd_q  <= sb_rd_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] dmiss_cnt_q, dmiss_cnt_d, lu_cnt_q, lu_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    dmiss_cnt_d = dmiss_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (dmiss && dmiss_cnt_q != '1) dmiss_cnt_d = dmiss_cnt_q + CNT_W'(1);
    if (advance && redirect && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (advance && !redirect && lu_hazard && lu_cnt_q != '1) lu_cnt_d = lu_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmiss_cnt_q <= '0;
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      dmiss_cnt_q <= dmiss_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_dmiss_cnt = dmiss_cnt_q;
  assign stall_lu_cnt    = lu_cnt_q;
  assign flush_cnt       = flush_cnt_q;
`else
  assign stall_dmiss_cnt = '0;
  assign stall_lu_cnt    = '0;
  assign flush_cnt       = '0;
`endif

endmodule
